// File: rtl/button_event_gen_if.sv
// Button event bundle: debounced levels in, per-channel event pulses and held level out.
// release/repeat are SystemVerilog keywords, hence the _pulse suffix on those two signals.
interface button_event_gen_if #(
  parameter int DATA_WIDTH = 1
);
  logic [DATA_WIDTH-1:0] din;
  logic [DATA_WIDTH-1:0] press;
  logic [DATA_WIDTH-1:0] release_pulse;
  logic [DATA_WIDTH-1:0] hold;
  logic [DATA_WIDTH-1:0] repeat_pulse;
  logic [DATA_WIDTH-1:0] held;

  modport master (
    output din,
    input  press, release_pulse, hold, repeat_pulse, held
  );

  modport slave (
    input  din,
    output press, release_pulse, hold, repeat_pulse, held
  );
endinterface

// File: rtl/button_event_gen.sv
// Per-channel button event generator: press/release edges, long-press hold and auto-repeat.
// Every channel owns its own FSM, cycle counter and previous-level register.
module button_event_gen #(
  parameter int DATA_WIDTH    = 1,
  parameter int HOLD_CYCLES   = 50000000,
  parameter int REPEAT_CYCLES = 10000000,
  parameter int CNT_WIDTH     = 26
) (
  input  logic               clk,
  input  logic               resetn,
  button_event_gen_if.slave  bus
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PRESSED = 2'd1;
  localparam logic [1:0] ST_HELD    = 2'd2;

  // Counters run 0..N-1, so expiry is detected one count early to land exactly N cycles after entry.
  localparam logic [CNT_WIDTH-1:0] HOLD_LAST   = CNT_WIDTH'(HOLD_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] REPEAT_LAST = CNT_WIDTH'(REPEAT_CYCLES - 1);

  for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_ch
    logic                 din_i;
    logic [1:0]           state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 din_q;
    logic                 press_q, press_d;
    logic                 release_q, release_d;
    logic                 hold_q, hold_d;
    logic                 repeat_q, repeat_d;
    logic                 held_q, held_d;

    assign din_i = bus.din[i];

    // A falling din is checked before counter expiry so release wins a same-edge collision.
    always_comb begin
      state_d   = state_q;
      cnt_d     = '0;
      press_d   = 1'b0;
      release_d = 1'b0;
      hold_d    = 1'b0;
      repeat_d  = 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (din_i && !din_q) begin
            state_d = ST_PRESSED;
            press_d = 1'b1;
          end
        end
        ST_PRESSED: begin
          if (!din_i) begin
            state_d   = ST_IDLE;
            release_d = 1'b1;
          end else if (cnt_q == HOLD_LAST) begin
            state_d = ST_HELD;
            hold_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
          end
        end
        ST_HELD: begin
          if (!din_i) begin
            state_d   = ST_IDLE;
            release_d = 1'b1;
          end else if (cnt_q == REPEAT_LAST) begin
            repeat_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
      held_d = (state_d == ST_HELD);
    end

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        state_q   <= ST_IDLE;
        cnt_q     <= '0;
        din_q     <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        hold_q    <= 1'b0;
        repeat_q  <= 1'b0;
        held_q    <= 1'b0;
      end else begin
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        din_q     <= din_i;
        press_q   <= press_d;
        release_q <= release_d;
        hold_q    <= hold_d;
        repeat_q  <= repeat_d;
        held_q    <= held_d;
      end
    end

    assign bus.press[i]         = press_q;
    assign bus.release_pulse[i] = release_q;
    assign bus.hold[i]          = hold_q;
    assign bus.repeat_pulse[i]  = repeat_q;
    assign bus.held[i]          = held_q;
  end

endmodule

// File: tb/tb_button_event_gen.sv
// Bench for button_event_gen: timing-arithmetic reference model checked every cycle,
// directed long/short/collision/independence/reset scenarios and a randomized phase.
module tb_button_event_gen;

  localparam int DW = 2;
  localparam int HC = 8;
  localparam int RC = 4;

  logic clk;
  logic resetn;

  button_event_gen_if #(.DATA_WIDTH(DW)) bus();

  button_event_gen #(
    .DATA_WIDTH(DW),
    .HOLD_CYCLES(HC),
    .REPEAT_CYCLES(RC),
    .CNT_WIDTH(26)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  int tp0[$], th0[$], tr0[$], tl0[$];
  int tp1[$], th1[$], tr1[$], tl1[$];

  task automatic check(input string name, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Reference: each press opens a run; events follow from the edge count since that press.
  int   start[DW];
  logic prev[DW];

  always @(posedge clk) begin
    logic [DW-1:0] d, ep, el, eh, er, ed;
    logic          rn;
    logic [5*DW-1:0] got, exp;
    int e;
    d  = bus.din;
    rn = resetn;
    cyc++;
    ep = '0; el = '0; eh = '0; er = '0; ed = '0;
    for (int c = 0; c < DW; c++) begin
      if (!rn) begin
        prev[c] = 1'b0;
      end else begin
        if (d[c] && !prev[c]) start[c] = cyc;
        e = cyc - start[c];
        ep[c] = d[c] && !prev[c];
        el[c] = !d[c] && prev[c];
        eh[c] = d[c] && prev[c] && (e == HC);
        er[c] = d[c] && prev[c] && (e > HC) && ((e - HC) % RC == 0);
        ed[c] = d[c] && (e >= HC);
        prev[c] = d[c];
      end
    end
    #1;
    got = {bus.press, bus.release_pulse, bus.hold, bus.repeat_pulse, bus.held};
    exp = {ep, el, eh, er, ed};
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL model cyc=%0d press/rel/hold/rpt/held got %b expected %b", cyc, got, exp);
    end
    if (bus.press[0])         tp0.push_back(cyc);
    if (bus.hold[0])          th0.push_back(cyc);
    if (bus.repeat_pulse[0])  tr0.push_back(cyc);
    if (bus.release_pulse[0]) tl0.push_back(cyc);
    if (bus.press[1])         tp1.push_back(cyc);
    if (bus.hold[1])          th1.push_back(cyc);
    if (bus.repeat_pulse[1])  tr1.push_back(cyc);
    if (bus.release_pulse[1]) tl1.push_back(cyc);
  end

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic int at(input int q[$], input int idx);
    return (idx < q.size()) ? q[idx] : -1000;
  endfunction

  initial begin
    int bp, bh, br, bl, bp1, bh1, br1, bl1, c_rst;
    int rem[DW];
    resetn  = 1'b0;
    bus.din = '0;
    #2;
    check("reset_outputs", int'({bus.press, bus.release_pulse, bus.hold, bus.repeat_pulse, bus.held}), 0);
    wait_neg(3);
    resetn = 1'b1;
    wait_neg(2);

    // Short press: 5 cycles, no hold.
    bp = tp0.size(); bh = th0.size(); bl = tl0.size();
    bus.din[0] = 1'b1; wait_neg(5); bus.din[0] = 1'b0; wait_neg(3);
    check("short_rel_minus_press", at(tl0, bl) - at(tp0, bp), 5);
    check("short_no_hold", th0.size() - bh, 0);

    // Long press: 20 cycles.
    bp = tp0.size(); bh = th0.size(); br = tr0.size(); bl = tl0.size();
    bus.din[0] = 1'b1; wait_neg(20); bus.din[0] = 1'b0; wait_neg(3);
    check("long_hold_offset", at(th0, bh) - at(tp0, bp), 8);
    check("long_rpt1_offset", at(tr0, br) - at(tp0, bp), 12);
    check("long_rpt2_offset", at(tr0, br + 1) - at(tp0, bp), 16);
    check("long_rpt_count", tr0.size() - br, 2);
    check("long_rel_offset", at(tl0, bl) - at(tp0, bp), 20);

    // Collision: fall on the hold-expiry edge.
    bp = tp0.size(); bh = th0.size(); bl = tl0.size();
    bus.din[0] = 1'b1; wait_neg(8); bus.din[0] = 1'b0; wait_neg(3);
    check("coll_rel_offset", at(tl0, bl) - at(tp0, bp), 8);
    check("coll_no_hold", th0.size() - bh, 0);

    // Independence: ch1 pressed 3 cycles after ch0, each held 15 cycles.
    bp = tp0.size(); bh = th0.size(); br = tr0.size(); bl = tl0.size();
    bp1 = tp1.size(); bh1 = th1.size(); br1 = tr1.size(); bl1 = tl1.size();
    bus.din[0] = 1'b1; wait_neg(3); bus.din[1] = 1'b1; wait_neg(12);
    bus.din[0] = 1'b0; wait_neg(3); bus.din[1] = 1'b0; wait_neg(3);
    check("ind_press_skew", at(tp1, bp1) - at(tp0, bp), 3);
    check("ind_hold_skew", at(th1, bh1) - at(th0, bh), 3);
    check("ind_rpt_skew", at(tr1, br1) - at(tr0, br), 3);
    check("ind_rel_skew", at(tl1, bl1) - at(tl0, bl), 3);
    check("ind_rel0_offset", at(tl0, bl) - at(tp0, bp), 15);

    // Release immediately followed by a new press.
    bp = tp0.size(); bl = tl0.size();
    bus.din[0] = 1'b1; wait_neg(3); bus.din[0] = 1'b0; wait_neg(1);
    bus.din[0] = 1'b1; wait_neg(4); bus.din[0] = 1'b0; wait_neg(3);
    check("repress_gap", at(tp0, bp + 1) - at(tl0, bl), 1);

    // Reset mid-hold with the button still down.
    bl = tl0.size();
    bus.din[0] = 1'b1; wait_neg(10);
    #2 resetn = 1'b0;
    #1;
    check("async_reset_outputs", int'({bus.press, bus.release_pulse, bus.hold, bus.repeat_pulse, bus.held}), 0);
    wait_neg(2);
    resetn = 1'b1;
    c_rst = cyc;
    bp = tp0.size(); bh = th0.size();
    wait_neg(12);
    check("reset_no_release", tl0.size() - bl, 0);
    bus.din[0] = 1'b0; wait_neg(3);
    check("post_reset_press", at(tp0, bp), c_rst + 1);
    check("post_reset_hold", at(th0, bh) - at(tp0, bp), 8);

    // Randomized phase, with occasional mid-cycle reset pulses.
    for (int c = 0; c < DW; c++) rem[c] = $urandom_range(1, 25);
    for (int n = 0; n < 1500; n++) begin
      for (int c = 0; c < DW; c++) begin
        rem[c]--;
        if (rem[c] <= 0) begin
          bus.din[c] = ~bus.din[c];
          rem[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(1, 25);
        end
      end
      if ($urandom_range(0, 299) == 0) begin
        #2 resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    bus.din = '0;
    wait_neg(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
